// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped cache controller.
package cache_pkg;

    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;
    localparam int   INDEX_W    = 8;
    localparam int   OFFSET_W   = 2;
    localparam int   LINE_BYTES = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_RD,
        S_RESP,
        S_FILL_REQ,
        S_FILL_WR,
        S_WR_RAM,
        S_MEM_WR,
        S_DONE
    } state_e;

endpackage

// File: rtl/cache_tag_array.sv
// Tag store and valid bits: combinational lookup, single posedge line-install port.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) valid_d[wr_index] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Tags carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) tag_q[wr_index] <= wr_tag;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller driving an
// external negedge-clocked byte RAM and a req/ack backing memory.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [7:0]        ram_index,
    output logic [1:0]        ram_byte,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [1:0]          k_q, k_d;
    logic                refill_q, refill_d;
    logic [7:0]          cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_rw_q, ram_rw_d;
    logic [7:0]          ram_index_q, ram_index_d;
    logic [1:0]          ram_byte_q, ram_byte_d;
    logic [7:0]          ram_din_q, ram_din_d;
    logic [CNT_W-1:0]    hit_q, hit_d, miss_q, miss_d;

    logic [TAG_W-1:0]    tag_w, lk_tag;
    logic [INDEX_W-1:0]  idx_w;
    logic                lk_valid, hit, tag_we;

    assign tag_w = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_w = addr_q[OFFSET_W +: INDEX_W];
    assign hit   = lk_valid && (lk_tag == tag_w);

    cache_tag_array #(.TAG_W(TAG_W)) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (idx_w),
        .rd_valid (lk_valid),
        .rd_tag   (lk_tag),
        .wr_en    (tag_we),
        .wr_index (idx_w),
        .wr_tag   (tag_w)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        k_d         = k_q;
        refill_d    = refill_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        mem_req_d   = mem_req_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ram_en_d    = 1'b0;
        ram_rw_d    = ram_rw_q;
        ram_index_d = ram_index_q;
        ram_byte_d  = ram_byte_q;
        ram_din_d   = ram_din_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        tag_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d   = cpu_addr;
                    rw_d     = cpu_rw;
                    wdata_d  = cpu_wdata;
                    refill_d = 1'b0;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                ram_index_d = idx_w;
                ram_byte_d  = addr_q[OFFSET_W-1:0];
                if (hit) begin
                    // The re-lookup after a fill was already counted as a miss.
                    if (!refill_q) hit_d = hit_q + CNT_W'(1);
                    ram_en_d = 1'b1;
                    if (rw_q == RW_READ) begin
                        ram_rw_d = RW_READ;
                        state_d  = S_RD;
                    end else begin
                        ram_rw_d  = RW_WRITE;
                        ram_din_d = wdata_q;
                        state_d   = S_WR_RAM;
                    end
                end else begin
                    miss_d    = miss_q + CNT_W'(1);
                    mem_req_d = 1'b1;
                    if (rw_q == RW_READ) begin
                        k_d        = 2'd0;
                        mem_rw_d   = RW_READ;
                        mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], 2'd0};
                        state_d    = S_FILL_REQ;
                    end else begin
                        mem_rw_d    = RW_WRITE;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = wdata_q;
                        state_d     = S_MEM_WR;
                    end
                end
            end
            S_RD: begin
                cpu_rdata_d = ram_dout;
                cpu_ready_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: state_d = S_IDLE;
            S_FILL_REQ: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    ram_en_d    = 1'b1;
                    ram_rw_d    = RW_WRITE;
                    ram_index_d = idx_w;
                    ram_byte_d  = k_q;
                    ram_din_d   = mem_rdata;
                    state_d     = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                if (k_q == 2'd3) begin
                    tag_we   = 1'b1;
                    refill_d = 1'b1;
                    state_d  = S_LOOKUP;
                end else begin
                    k_d        = k_q + 2'd1;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], k_q + 2'd1};
                    state_d    = S_FILL_REQ;
                end
            end
            S_WR_RAM: begin
                mem_req_d   = 1'b1;
                mem_rw_d    = RW_WRITE;
                mem_addr_d  = addr_q;
                mem_wdata_d = wdata_q;
                state_d     = S_MEM_WR;
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    cpu_ready_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            k_q         <= '0;
            refill_q    <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ram_en_q    <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_index_q <= '0;
            ram_byte_q  <= '0;
            ram_din_q   <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            k_q         <= k_d;
            refill_q    <= refill_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ram_en_q    <= ram_en_d;
            ram_rw_q    <= ram_rw_d;
            ram_index_q <= ram_index_d;
            ram_byte_q  <= ram_byte_d;
            ram_din_q   <= ram_din_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ready  = cpu_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign ram_en     = ram_en_q;
    assign ram_rw     = ram_rw_q;
    assign ram_index  = ram_index_q;
    assign ram_byte   = ram_byte_q;
    assign ram_din    = ram_din_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: models the data RAM, backing memory and
// the expected hit/miss behaviour of a direct-mapped write-through cache.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_rw = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0, cpu_rdata;
    logic        cpu_ready;
    logic        mem_req, mem_rw;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        ram_en, ram_rw;
    logic [7:0]  ram_index, ram_din, ram_dout = '0;
    logic [1:0]  ram_byte;
    logic [15:0] hit_count, miss_count;

    cache_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_index(ram_index), .ram_byte(ram_byte),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;

    op_t  sb_q[$];
    op_t  mem_exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   mem_wait = 0;
    int   n_acks = 0;
    int   ram_pulses = 0;

    logic [7:0] dram [1024];
    logic [7:0] mem_arr [int];
    logic [7:0] ref_arr [int];

    bit         m_valid [256];
    logic [5:0] m_tag   [256];
    int         m_hits = 0, m_misses = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return mem_arr.exists(int'(a)) ? mem_arr[int'(a)] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_arr.exists(int'(a)) ? ref_arr[int'(a)] : dflt(a);
    endfunction

    // Data RAM: reads and writes happen at negedge.
    always @(negedge clk) begin
        if (ram_en) begin
            ram_pulses++;
            if (ram_rw) ram_dout = dram[{ram_index, ram_byte}];
            else        dram[{ram_index, ram_byte}] = ram_din;
        end
    end

    // Backing memory responder with programmable wait states.
    int wcnt = 0;
    always @(negedge clk) begin
        op_t e;
        if (!rst_n) begin
            mem_ack = 1'b0;
            wcnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt = 0;
            check("mem_req_drop", {31'd0, mem_req}, 32'd0);
        end else if (mem_req) begin
            if (wcnt < mem_wait) begin
                wcnt++;
            end else begin
                if (mem_exp_q.size() == 0) begin
                    check("mem_op_unexpected", mem_exp_q.size(), 1);
                end else begin
                    e = mem_exp_q.pop_front();
                    check("mem_rw", {31'd0, mem_rw}, {31'd0, e.rw});
                    check("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                    if (!e.rw) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
                end
                if (mem_rw) mem_rdata = mem_rd(mem_addr);
                else        mem_arr[int'(mem_addr)] = mem_wdata;
                mem_ack = 1'b1;
                n_acks++;
            end
        end
    end

    // CPU-side scoreboard: every completion pops one expected response.
    always @(negedge clk) begin
        op_t e;
        if (rst_n && cpu_ready) begin
            if (sb_q.size() == 0) begin
                check("cpu_ready_unexpected", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                if (e.rw) check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e.data});
            end
        end
    end

    task automatic do_req(input logic rw, input logic [15:0] a, input logic [7:0] wd);
        logic [7:0] idx = a[9:2];
        logic [5:0] tg  = a[15:10];
        bit         hit = m_valid[idx] && (m_tag[idx] == tg);
        int         exp_pulses, p0, cycles;
        op_t        o;
        if (rw) begin
            o = '{1'b1, a, ref_rd(a)};
            sb_q.push_back(o);
            if (hit) begin
                m_hits++;
                exp_pulses = 1;
            end else begin
                m_misses++;
                exp_pulses = 5;
                for (int k = 0; k < 4; k++) begin
                    o = '{1'b1, {a[15:2], 2'(k)}, 8'h00};
                    mem_exp_q.push_back(o);
                end
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end else begin
            o = '{1'b0, a, wd};
            sb_q.push_back(o);
            mem_exp_q.push_back(o);
            ref_arr[int'(a)] = wd;
            if (hit) begin
                m_hits++;
                exp_pulses = 1;
            end else begin
                m_misses++;
                exp_pulses = 0;
            end
        end
        @(negedge clk);
        p0 = ram_pulses;
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!cpu_ready && cycles < 300);
        cpu_req = 1'b0;
        if (!cpu_ready) check("req_timeout", cycles, 0);
        if (rw && hit) check("rd_hit_latency", cycles, 3);
        @(negedge clk);
        check("cpu_ready_pulse", {31'd0, cpu_ready}, 32'd0);
        check("ram_pulses", ram_pulses - p0, exp_pulses);
        check("mem_ops_left", mem_exp_q.size(), 0);
        check("hit_count", {16'd0, hit_count}, m_hits);
        check("miss_count", {16'd0, miss_count}, m_misses);
    endtask

    initial begin
        logic [5:0] tags [4];
        logic [7:0] idxs [3];
        int         cyc;
        tags[0] = 6'h01; tags[1] = 6'h04; tags[2] = 6'h15; tags[3] = 6'h22;
        idxs[0] = 8'h8D; idxs[1] = 8'h00; idxs[2] = 8'h10;
        for (int i = 0; i < 4; i++) begin
            mem_arr[32'h1234 + i] = 8'hA0 + 8'(i);
            ref_arr[32'h1234 + i] = 8'hA0 + 8'(i);
        end

        repeat (3) @(negedge clk);
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check("rst_hit_count", {16'd0, hit_count}, 32'd0);
        check("rst_miss_count", {16'd0, miss_count}, 32'd0);
        rst_n = 1'b1;

        mem_wait = 0;
        do_req(1'b1, 16'h1234, 8'h00);   // miss + fill, expects 0xA0
        do_req(1'b1, 16'h1236, 8'h00);   // hit, expects 0xA2
        do_req(1'b0, 16'h1235, 8'h55);   // write hit
        do_req(1'b1, 16'h1235, 8'h00);   // hit, returns 0x55
        do_req(1'b0, 16'h8800, 8'h77);   // write miss, no RAM access
        do_req(1'b1, 16'h8800, 8'h00);   // miss, fill brings 0x77
        do_req(1'b1, 16'h5634, 8'h00);   // conflict on index 0x8D
        do_req(1'b1, 16'h1234, 8'h00);   // evicted, misses again

        for (int i = 0; i < 24; i++) begin
            logic [15:0] a;
            mem_wait = $urandom_range(0, 3);
            a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 2)], 2'($urandom_range(0, 3))};
            do_req(1'($urandom_range(0, 1)), a, 8'($urandom));
        end

        // Reset while the third fill request is waiting on memory.
        mem_wait = 8;
        for (int k = 0; k < 3; k++) mem_exp_q.push_back('{1'b1, {14'h091A, 2'(k)}, 8'h00});
        @(negedge clk);
        n_acks = 0;
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h2468;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(n_acks == 2 && mem_req) && cyc < 300);
        if (cyc >= 300) check("abort_timeout", cyc, 0);
        @(negedge clk);
        cpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        check("abort_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("abort_ram_en", {31'd0, ram_en}, 32'd0);
        check("abort_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("abort_miss_count", {16'd0, miss_count}, 32'd0);
        mem_exp_q.delete();
        sb_q.delete();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_wait = 1;
        do_req(1'b1, 16'h2468, 8'h00);   // line was left invalid: misses
        do_req(1'b1, 16'h246B, 8'h00);   // now hits

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate controller that sequences the byte-wide cache data RAM (256 lines × 4 bytes, negedge-clocked) on behalf of one CPU requester.
- Owns the tag/valid array, performs the 4-byte line fill from backing memory over a req/ack handshake, and drives all RAM strobes.
- Sits between the CPU port and the cache data RAM plus the memory port.

Parameters:
ADDR_W, 16, byte address width; tag width TAG_W = ADDR_W-10 (localparam)
CNT_W, 16, width of hit/miss performance counters

Ports:
clk  in  1  system clock; controller logic on posedge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  request; sampled only in IDLE; CPU holds fields stable until cpu_ready
cpu_rw  in  1  1=read, 0=write
cpu_addr  in  ADDR_W  {tag, index[7:0], byte[1:0]}
cpu_wdata  in  8  write byte
cpu_rdata  out  8  read byte, valid while cpu_ready
cpu_ready  out  1  one-cycle completion pulse
mem_req  out  1  memory request, held until mem_ack
mem_rw  out  1  1=read, 0=write
mem_addr  out  ADDR_W  byte address
mem_wdata  out  8  write byte
mem_rdata  in  8  valid in the mem_ack cycle
mem_ack  in  1  one-cycle acknowledge
ram_en, ram_rw  out  1 each  data-RAM enable / rw (1=read, 0=write)
ram_index  out  8  data-RAM line
ram_byte  out  2  data-RAM byte lane
ram_din  out  8  data-RAM write data
ram_dout  in  8  data-RAM read data, updated at negedge
hit_count, miss_count  out  CNT_W  wrapping performance counters

Behaviour:
- Reset (async): state=IDLE; all valid bits=0; cpu_ready, cpu_rdata, mem_req, mem_rw, mem_addr, mem_wdata, ram_en, ram_rw, ram_index, ram_byte, ram_din, hit_count, miss_count all 0. Tags are not reset.
- RAM strobes are registered at posedge so they are stable at the following negedge; ram_en is high for exactly one cycle per access.
- States:
  - IDLE: on cpu_req, latch addr/rw/wdata → LOOKUP.
  - LOOKUP: hit = valid[index] && tag match.
    - Read hit → RD: ram_en=1, ram_rw=1; hit_count++.
    - Read miss → FILL_REQ with k=0; miss_count++.
    - Write hit → WR_RAM: ram_en=1, ram_rw=0, ram_din=wdata; hit_count++.
    - Write miss → MEM_WR; miss_count++.
  - RD: RAM reads at mid-cycle negedge → RESP: cpu_rdata<=ram_dout, cpu_ready=1 for one cycle → IDLE.
  - FILL_REQ: mem_req=1, mem_rw=1, mem_addr={tag,index,k}; hold until mem_ack. On ack: latch mem_rdata, drop mem_req → FILL_WR.
  - FILL_WR: write byte k (ram_rw=0, ram_byte=k).
    - k<3: k++ → FILL_REQ.
    - k=3: set valid[index], tag[index]; miss_count not incremented again → LOOKUP, which re-looks up and now hits.
  - WR_RAM → MEM_WR.
  - MEM_WR: mem_req=1, mem_rw=0, mem_addr=addr, mem_wdata=wdata until mem_ack → DONE: cpu_ready=1 → IDLE.
- Latency, counting posedges after the accept edge:
  - Read hit: cpu_ready high in cycle 3.
  - Read miss with 0-wait memory (ack in first req cycle): 4×2 fill cycles + 3.
  - Write: 2 (miss) or 3 (hit) cycles + memory wait.
- mem_req drops in the cycle after ack; it is never re-asserted in the ack cycle.
- cpu_req asserted outside IDLE is ignored. A request held across the cpu_ready cycle is accepted on the next IDLE edge.
- Fill to a valid line with a different tag: valid stays set during the fill, but the tag is updated only at k=3. The controller is single-requester, so no intermediate lookup can occur.
- rst_n asserted mid-fill: the line is left invalid and mem_req drops asynchronously. The memory side must tolerate the aborted request.
- Counters wrap at 2^CNT_W.

Decomposition:
- Package cache_pkg holds:
  - state enum
  - RW_READ=1'b1, RW_WRITE=1'b0
  - INDEX_W=8, OFFSET_W=2, LINE_BYTES=4
- Sub-module cache_tag_array: 256 × TAG_W tag regs plus 256 async-reset valid bits; combinational lookup port and one posedge write port (set valid+tag).

Test Plan:
- Reset, then read 0x1234 → miss: 4 mem reads at 0x1234,0x1235,0x1236,0x1237 in that order (reference count lists 0x1234..0x1237 by byte lane 0..3: 0x1234,0x1235,0x1236,0x1237), fed 0xA0..0xA3 → cpu_rdata=0xA0; miss_count=1.
- Read 0x1236 immediately after → hit, no mem_req, cpu_ready in cycle 3, cpu_rdata=0xA2; hit_count=1.
- Write 0x55 to 0x1235 (hit), then read 0x1235 → mem write addr 0x1235 data 0x55, subsequent read returns 0x55 with no fill.
- Write 0x77 to 0x8800 (miss) → single mem write, no ram_en pulse; read 0x8800 then misses and fills.
- Conflict: after filling 0x1234, read 0x5634 (same index 0x8D, different tag) → refill replaces the line; re-read 0x1234 misses again.
- Assert rst_n low during the third FILL_REQ wait → mem_req low immediately, outputs 0; the next read of the same address misses.
